// File: rtl/pic10_fetch_unit.sv
// pic10_fetch_unit: PC, instruction register and 2-level call stack for the PIC10 core.
// Optional build macro PIC10_STACK_STATUS_EN adds stack_depth / stack_err status outputs.
// Revision: 1.0
`default_nettype none

module pic10_fetch_unit #(
   parameter logic [8:0]  RESET_VECTOR = 9'h1FF,
   parameter logic [11:0] NOP_WORD     = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [8:0]  pc_bus,
   input  logic [11:0] program_bus,
   output logic [11:0] ir,
   output logic        ir_valid,
   input  logic        stall,
   input  logic        goto_en,
   input  logic        call_en,
   input  logic        ret_en,
   input  logic        pcl_wr,
   input  logic        skip,
   input  logic [8:0]  target,
   input  logic [7:0]  pcl_data
`ifdef PIC10_STACK_STATUS_EN
   ,
   output logic [1:0]  stack_depth,
   output logic        stack_err
`endif
);

   logic [8:0] r_stack0;
   logic [8:0] r_stack1;

   // pc_bus is the PC register itself, so it doubles as the CALL return address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_bus   <= RESET_VECTOR;
         ir       <= NOP_WORD;
         ir_valid <= 1'b0;
         r_stack0 <= 9'h000;
         r_stack1 <= 9'h000;
      end else if (!stall) begin
         if (ret_en) begin
            pc_bus   <= r_stack0;
            r_stack0 <= r_stack1;
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
         end else if (call_en) begin
            r_stack1 <= r_stack0;
            r_stack0 <= pc_bus;
            pc_bus   <= {1'b0, target[7:0]};
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
         end else if (goto_en) begin
            pc_bus   <= target;
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
         end else if (pcl_wr) begin
            pc_bus   <= {1'b0, pcl_data};
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
         end else if (skip) begin
            pc_bus   <= pc_bus + 9'd1;
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
         end else begin
            pc_bus   <= pc_bus + 9'd1;
            ir       <= program_bus;
            ir_valid <= 1'b1;
         end
      end
   end

`ifdef PIC10_STACK_STATUS_EN
   logic w_push;
   logic w_pop;

   assign w_pop  = !stall && ret_en;
   assign w_push = !stall && !ret_en && call_en;

   // Depth saturates at both ends; any out-of-range push/pop latches the error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stack_depth <= 2'd0;
         stack_err   <= 1'b0;
      end else if (w_pop) begin
         if (stack_depth == 2'd0) begin
            stack_err <= 1'b1;
         end else begin
            stack_depth <= stack_depth - 2'd1;
         end
      end else if (w_push) begin
         if (stack_depth == 2'd2) begin
            stack_err <= 1'b1;
         end else begin
            stack_depth <= stack_depth + 2'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pic10_fetch_unit.sv
// tb_pic10_fetch_unit: table-driven scoreboard bench for pic10_fetch_unit.
// Revision: 1.0
`default_nettype none

module tb_pic10_fetch_unit;

   localparam logic [5:0] NO = 6'b000000;
   localparam logic [5:0] ST = 6'b100000;
   localparam logic [5:0] GO = 6'b010000;
   localparam logic [5:0] CA = 6'b001000;
   localparam logic [5:0] RT = 6'b000100;
   localparam logic [5:0] PW = 6'b000010;
   localparam logic [5:0] SK = 6'b000001;
   localparam int         NVEC = 34;

   typedef struct {
      logic [5:0]  ctl;
      logic [8:0]  tgt;
      logic [7:0]  pd;
      logic [8:0]  pc;
      logic [11:0] ir;
      logic        valid;
      logic [1:0]  depth;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [8:0]  pc_bus;
   logic [11:0] program_bus;
   logic [11:0] ir;
   logic        ir_valid;
   logic        stall = 1'b0, goto_en = 1'b0, call_en = 1'b0;
   logic        ret_en = 1'b0, pcl_wr = 1'b0, skip = 1'b0;
   logic [8:0]  target = 9'h000;
   logic [7:0]  pcl_data = 8'h00;
`ifdef PIC10_STACK_STATUS_EN
   logic [1:0]  stack_depth;
   logic        stack_err;
`endif

   logic [11:0] mem [512];
   vec_t        vecs [NVEC];
   vec_t        exp_q [$];
   int          n_cmp = 0;
   int          n_fail = 0;

   assign program_bus = mem[pc_bus];

   always #5 clk = ~clk;

   pic10_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_bus      (pc_bus),
      .program_bus (program_bus),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .stall       (stall),
      .goto_en     (goto_en),
      .call_en     (call_en),
      .ret_en      (ret_en),
      .pcl_wr      (pcl_wr),
      .skip        (skip),
      .target      (target),
      .pcl_data    (pcl_data)
`ifdef PIC10_STACK_STATUS_EN
      ,
      .stack_depth (stack_depth),
      .stack_err   (stack_err)
`endif
   );

   function automatic vec_t mk(input logic [5:0] c, input logic [8:0] t, input logic [7:0] p,
                               input logic [8:0] epc, input logic [11:0] eir, input logic ev,
                               input logic [1:0] ed, input logic ee);
      vec_t v;
      v.ctl = c; v.tgt = t; v.pd = p; v.pc = epc; v.ir = eir; v.valid = ev;
      v.depth = ed; v.err = ee;
      return v;
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag, input vec_t e);
      chk({tag, " pc_bus"}, {3'b000, pc_bus}, {3'b000, e.pc});
      chk({tag, " ir"}, ir, e.ir);
      chk({tag, " ir_valid"}, {11'h000, ir_valid}, {11'h000, e.valid});
`ifdef PIC10_STACK_STATUS_EN
      chk({tag, " stack_depth"}, {10'h000, stack_depth}, {10'h000, e.depth});
      chk({tag, " stack_err"}, {11'h000, stack_err}, {11'h000, e.err});
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t e;
      for (int a = 0; a < 511; a++) mem[a] = 12'(a) + 12'h100;
      mem[511] = 12'hC25;

      // Sequential fetch out of reset, GOTO, PCL write, CALL/RETLW, nested calls,
      // skip with wrap, priority collisions and stall.
      vecs[0]  = mk(NO, 9'h000, 8'h00, 9'h000, 12'hC25, 1'b1, 2'd0, 1'b0);
      vecs[1]  = mk(NO, 9'h000, 8'h00, 9'h001, 12'h100, 1'b1, 2'd0, 1'b0);
      vecs[2]  = mk(NO, 9'h000, 8'h00, 9'h002, 12'h101, 1'b1, 2'd0, 1'b0);
      vecs[3]  = mk(NO, 9'h000, 8'h00, 9'h003, 12'h102, 1'b1, 2'd0, 1'b0);
      vecs[4]  = mk(NO, 9'h000, 8'h00, 9'h004, 12'h103, 1'b1, 2'd0, 1'b0);
      vecs[5]  = mk(NO, 9'h000, 8'h00, 9'h005, 12'h104, 1'b1, 2'd0, 1'b0);
      vecs[6]  = mk(GO, 9'h0A0, 8'h00, 9'h0A0, 12'h000, 1'b0, 2'd0, 1'b0);
      vecs[7]  = mk(NO, 9'h000, 8'h00, 9'h0A1, 12'h1A0, 1'b1, 2'd0, 1'b0);
      vecs[8]  = mk(PW, 9'h000, 8'h10, 9'h010, 12'h000, 1'b0, 2'd0, 1'b0);
      vecs[9]  = mk(CA, 9'h1F3, 8'h00, 9'h0F3, 12'h000, 1'b0, 2'd1, 1'b0);
      vecs[10] = mk(NO, 9'h000, 8'h00, 9'h0F4, 12'h1F3, 1'b1, 2'd1, 1'b0);
      vecs[11] = mk(RT, 9'h000, 8'h00, 9'h010, 12'h000, 1'b0, 2'd0, 1'b0);
      vecs[12] = mk(NO, 9'h000, 8'h00, 9'h011, 12'h110, 1'b1, 2'd0, 1'b0);
      vecs[13] = mk(GO, 9'h020, 8'h00, 9'h020, 12'h000, 1'b0, 2'd0, 1'b0);
      vecs[14] = mk(CA, 9'h030, 8'h00, 9'h030, 12'h000, 1'b0, 2'd1, 1'b0);
      vecs[15] = mk(CA, 9'h040, 8'h00, 9'h040, 12'h000, 1'b0, 2'd2, 1'b0);
      vecs[16] = mk(CA, 9'h050, 8'h00, 9'h050, 12'h000, 1'b0, 2'd2, 1'b1);
      vecs[17] = mk(NO, 9'h000, 8'h00, 9'h051, 12'h150, 1'b1, 2'd2, 1'b1);
      vecs[18] = mk(RT, 9'h000, 8'h00, 9'h040, 12'h000, 1'b0, 2'd1, 1'b1);
      vecs[19] = mk(RT, 9'h000, 8'h00, 9'h030, 12'h000, 1'b0, 2'd0, 1'b1);
      vecs[20] = mk(RT, 9'h000, 8'h00, 9'h030, 12'h000, 1'b0, 2'd0, 1'b1);
      vecs[21] = mk(NO, 9'h000, 8'h00, 9'h031, 12'h130, 1'b1, 2'd0, 1'b1);
      vecs[22] = mk(GO, 9'h1FF, 8'h00, 9'h1FF, 12'h000, 1'b0, 2'd0, 1'b1);
      vecs[23] = mk(SK, 9'h000, 8'h00, 9'h000, 12'h000, 1'b0, 2'd0, 1'b1);
      vecs[24] = mk(NO, 9'h000, 8'h00, 9'h001, 12'h100, 1'b1, 2'd0, 1'b1);
      vecs[25] = mk(GO | PW | SK, 9'h080, 8'h22, 9'h080, 12'h000, 1'b0, 2'd0, 1'b1);
      vecs[26] = mk(RT | CA, 9'h044, 8'h00, 9'h030, 12'h000, 1'b0, 2'd0, 1'b1);
      vecs[27] = mk(CA | GO, 9'h1C5, 8'h00, 9'h0C5, 12'h000, 1'b0, 2'd1, 1'b1);
      vecs[28] = mk(NO, 9'h000, 8'h00, 9'h0C6, 12'h1C5, 1'b1, 2'd1, 1'b1);
      vecs[29] = mk(ST | GO, 9'h0A0, 8'h00, 9'h0C6, 12'h1C5, 1'b1, 2'd1, 1'b1);
      vecs[30] = mk(ST | RT, 9'h0A0, 8'h00, 9'h0C6, 12'h1C5, 1'b1, 2'd1, 1'b1);
      vecs[31] = mk(ST | CA, 9'h0A0, 8'h00, 9'h0C6, 12'h1C5, 1'b1, 2'd1, 1'b1);
      vecs[32] = mk(GO, 9'h0A0, 8'h00, 9'h0A0, 12'h000, 1'b0, 2'd1, 1'b1);
      vecs[33] = mk(ST | GO, 9'h0B0, 8'h00, 9'h0A0, 12'h000, 1'b0, 2'd1, 1'b1);

      #1 rst_n = 1'b0;
      #1;
      e = mk(NO, 9'h000, 8'h00, 9'h1FF, 12'h000, 1'b0, 2'd0, 1'b0);
      check_outputs("reset", e);
      #10 rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         {stall, goto_en, call_en, ret_en, pcl_wr, skip} = vecs[i].ctl;
         target   = vecs[i].tgt;
         pcl_data = vecs[i].pd;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check_outputs($sformatf("vec%0d", i), e);
      end

      // Asynchronous reset pulsed in the middle of a stall, between clock edges.
      #2 rst_n = 1'b0;
      #1;
      e = mk(NO, 9'h000, 8'h00, 9'h1FF, 12'h000, 1'b0, 2'd0, 1'b0);
      check_outputs("midstall_reset", e);
      #2 rst_n = 1'b1;
      {stall, goto_en, call_en, ret_en, pcl_wr, skip} = NO;
      @(posedge clk);
      #1;
      e = mk(NO, 9'h000, 8'h00, 9'h000, 12'hC25, 1'b1, 2'd0, 1'b0);
      check_outputs("post_reset_fetch", e);
      @(posedge clk);
      #1;
      e = mk(NO, 9'h000, 8'h00, 9'h001, 12'h100, 1'b1, 2'd0, 1'b0);
      check_outputs("post_reset_fetch2", e);

      $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
